// File: rtl/boot_pkg.sv
// Shared FSM state encoding for the boot loader and anything observing it.
package boot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    OVF  = 2'd3
  } boot_state_t;

endpackage

// File: rtl/boot_mem_mux.sv
// Memory-port ownership mux: controller drives memory when sel_ctrl, else the loader.
// Purely combinational, zero latency; no backpressure (memory always accepts).
module boot_mem_mux #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              sel_ctrl,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_en,
  input  logic              ld_write,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic [DATA_W-1:0] ctrl_to_mem,
  input  logic              ctrl_mem_en,
  input  logic              ctrl_mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_write
);

  always_comb begin
    if (sel_ctrl) begin
      mem_addr  = ctrl_addr;
      mem_wdata = ctrl_to_mem;
      mem_en    = ctrl_mem_en;
      mem_write = ctrl_mem_write;
    end else begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_en    = ld_en;
      mem_write = ld_write;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Streams a program image into memory from LOAD_BASE, then hands memory to the controller.
// Writes commit on the accepting edge (zero latency); in_ready is high for the whole of LOAD.
module boot_loader
  import boot_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic [DATA_W-1:0] ctrl_to_mem,
  input  logic              ctrl_mem_en,
  input  logic              ctrl_mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_write,
  output logic              ctrl_run,
  output logic              busy,
  output logic [ADDR_W:0]   load_count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  boot_state_t       state;
  logic [ADDR_W-1:0] ptr;
  logic              beat_acc;

  // in_ready is only ever high in LOAD, so it doubles as the LOAD qualifier.
  assign beat_acc = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= LOAD_BASE;
      load_count <= '0;
      overflow   <= 1'b0;
      in_ready   <= 1'b0;
      ctrl_run   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (beat_acc) begin
            ptr        <= ptr + PTR_ONE;
            load_count <= load_count + CNT_ONE;
            if (in_last) begin
              state    <= RUN;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              ctrl_run <= 1'b1;
            end else if (ptr == '1) begin
              // Last address written with more data pending: stop rather than wrap.
              state    <= OVF;
              overflow <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end
        default: begin
          if (start) begin
            state      <= LOAD;
            ptr        <= LOAD_BASE;
            load_count <= '0;
            overflow   <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            ctrl_run   <= 1'b0;
          end
        end
      endcase
    end
  end

  boot_mem_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem_mux (
    .sel_ctrl       (state == RUN),
    .ld_addr        (ptr),
    .ld_wdata       (in_data),
    .ld_en          (beat_acc),
    .ld_write       (beat_acc),
    .ctrl_addr      (ctrl_addr),
    .ctrl_to_mem    (ctrl_to_mem),
    .ctrl_mem_en    (ctrl_mem_en),
    .ctrl_mem_write (ctrl_mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_en         (mem_en),
    .mem_write      (mem_write)
  );

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
- REQ-001 The block SHALL have parameter DATA_W, default 8, the memory word width in bits.
- REQ-002 The block SHALL have parameter ADDR_W, default 8, the memory address width in bits.
- REQ-003 The block SHALL have parameter LOAD_BASE, default 0, the first address written by a load.
- REQ-004 The block SHALL use one clock and an asynchronous, active-low reset: clock (in, 1) is the single clock, rising-edge; reset_n (in, 1) is the asynchronous active-low reset.
- REQ-005 Port start (in, 1) SHALL be a one-cycle request to begin or restart a load.
- REQ-006 Ports in_data (in, DATA_W), in_valid (in, 1) and in_last (in, 1) SHALL form the program stream; in_ready (out, 1) is its ready.
- REQ-007 Ports ctrl_addr (in, ADDR_W), ctrl_to_mem (in, DATA_W), ctrl_mem_en (in, 1) and ctrl_mem_write (in, 1) SHALL be the controller's memory request.
- REQ-008 Ports mem_addr (out, ADDR_W), mem_wdata (out, DATA_W), mem_en (out, 1) and mem_write (out, 1) SHALL drive the memory port.
- REQ-009 Port ctrl_run (out, 1) SHALL be high only while the controller owns memory and may execute.
- REQ-010 Port busy (out, 1) SHALL be high while a load is in progress.
- REQ-011 Port load_count (out, ADDR_W+1) SHALL give the number of words written by the current or last load.
- REQ-012 Port overflow (out, 1) SHALL be a sticky load-overflow flag.

Function
- REQ-013 The FSM SHALL have states IDLE, LOAD, RUN and OVF.
- REQ-014 In IDLE, start SHALL move the FSM to LOAD, set ptr=LOAD_BASE, load_count=0 and overflow=0.
- REQ-015 In LOAD, in_ready SHALL be 1; a beat is accepted when in_valid&&in_ready.
- REQ-016 On an accepted beat, in the same cycle, mem_en=1, mem_write=1, mem_addr=ptr and mem_wdata=in_data; the write SHALL commit at that clock edge with zero extra latency.
- REQ-017 Each accepted beat SHALL increment ptr (modulo 2^ADDR_W) and load_count by 1 at the edge.
- REQ-018 An accepted beat with in_last=1 SHALL move the FSM to RUN at the next edge; the minimum load is 1 word.
- REQ-019 An accepted beat at ptr=2^ADDR_W-1 with in_last=0 SHALL still be written, then move the FSM to OVF and set overflow=1.
- REQ-020 In OVF, in_ready=0, ctrl_run=0 and mem_en=0; only start or reset SHALL leave OVF (start goes to LOAD as in REQ-014).
- REQ-021 In LOAD with in_valid=0, mem_en and mem_write SHALL be 0.
- REQ-022 In RUN, mem_* SHALL equal the ctrl_* inputs combinationally (addr, wdata, en, write) and ctrl_run SHALL be 1.
- REQ-023 Outside RUN, the ctrl_* inputs SHALL have no effect on mem_*.
- REQ-024 start in RUN SHALL restart the load: ctrl_run falls at the next edge and the FSM enters LOAD as in REQ-014.
- REQ-025 start in LOAD SHALL be ignored, and start coinciding with an accepted beat SHALL be ignored.
- REQ-026 busy SHALL be 1 exactly in LOAD.
- REQ-027 load_count SHALL hold its value in RUN and OVF.

Reset
- REQ-028 While reset_n=0, the block SHALL be in IDLE with ptr=LOAD_BASE, load_count=0, overflow=0, in_ready=0, ctrl_run=0, busy=0, mem_en=0 and mem_write=0, applied asynchronously.
- REQ-029 Reset during LOAD or RUN SHALL abandon the operation; words already written stay in memory.
- REQ-030 On reset release, the first state change SHALL require start.

Structure
- REQ-031 The state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, OVF=2'd3) SHALL live in the shared package boot_pkg, used by RTL and bench.
- REQ-032 The mem_* ownership multiplexer SHALL be the single sub-module boot_mem_mux (combinational, select=RUN).
- REQ-033 The FSM, ptr, load_count and overflow SHALL reside in boot_loader.

Verification
- REQ-034 The bench SHALL cover this case: reset, start, 4 beats 0x11,0x22,0x33,0x44 with last on the 4th -> memory[0..3] holds those values, load_count=4, ctrl_run=1 one cycle after the last beat.
- REQ-035 The bench SHALL cover this case: in_valid toggled 1/0 over 3 beats -> mem_en=1 only on accepted cycles, addresses 0,1,2 with no gaps, load_count=3.
- REQ-036 The bench SHALL cover this case: LOAD_BASE=0xFE, ADDR_W=8, 3 beats with no last -> writes at 0xFE and 0xFF, then OVF, overflow=1, in_ready=0, 3rd beat not written.
- REQ-037 The bench SHALL cover this case: in RUN, ctrl_addr=0x02 with ctrl_mem_en=1 and ctrl_mem_write=0 -> mem_addr=0x02 in the same cycle and read data equals the loaded 0x33.
- REQ-038 The bench SHALL cover this case: start in RUN, then reload 2 words 0xAA,0xBB -> ctrl_run low during LOAD, memory[0..1]=0xAA,0xBB, load_count=2.
- REQ-039 The bench SHALL cover this case: reset_n pulsed low mid-LOAD after 2 beats -> all outputs at reset values immediately, and no write occurs until the next start.
